// File: rtl/plane_bitmap_allocator.sv
// -----------------------------------------------------------------------------
// plane_bitmap_allocator
//   Tracks which flash planes are allocated in a busy bitmap. Each plane also
//   records the host that owns it, and each host has a held-plane count that
//   is capped at HOST_QUOTA.
//   Allocation is a three-state one-hot FSM:
//     IDLE   - accept one request
//     SEARCH - pick a candidate plane and commit it
//     GRANT  - hold the response until the consumer takes it
//   A release can arrive in any state. It takes effect on the same clock edge.
//
// Ports
//   i_clk, i_rst_n         clock, async active-low reset
//   i_alloc_*              allocation request (host, any/specific, plane)
//   o_alloc_ready          allocator is in IDLE and can take a request
//   o_grant_*              registered grant response, held until i_grant_ready
//   i_free_valid/plane_id  plane release, always accepted
//   o_busy_bitmap          bit p set when plane p is allocated
//   o_free_count           registered count of clear bits in o_busy_bitmap
//   o_err_free_idle        one-cycle pulse after a release of a non-busy plane
//
// Plane ids must be below MAX_PLANE_NUMBER.
// -----------------------------------------------------------------------------
module plane_bitmap_allocator #(
    parameter int MAX_HOST_NUMBER  = 4,
    parameter int MAX_PLANE_NUMBER = 16,
    parameter int HOST_QUOTA       = 4,
    localparam int HID_W = $clog2(MAX_HOST_NUMBER),
    localparam int PID_W = $clog2(MAX_PLANE_NUMBER),
    localparam int CNT_W = $clog2(MAX_PLANE_NUMBER + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_alloc_valid,
    input  logic [HID_W-1:0]            i_alloc_host_id,
    input  logic                        i_alloc_any,
    input  logic [PID_W-1:0]            i_alloc_plane_id,
    output logic                        o_alloc_ready,
    output logic                        o_grant_valid,
    output logic                        o_grant_ok,
    output logic [HID_W-1:0]            o_grant_host_id,
    output logic [PID_W-1:0]            o_grant_plane_id,
    input  logic                        i_grant_ready,
    input  logic                        i_free_valid,
    input  logic [PID_W-1:0]            i_free_plane_id,
    output logic [MAX_PLANE_NUMBER-1:0] o_busy_bitmap,
    output logic [CNT_W-1:0]            o_free_count,
    output logic                        o_err_free_idle
);

    localparam int QCNT_W = $clog2(HOST_QUOTA + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SEARCH = 3'b010,
        ST_GRANT  = 3'b100
    } state_t;

    // Count the clear bits of a plane vector.
    function automatic logic [CNT_W-1:0] count_zeros(input logic [MAX_PLANE_NUMBER-1:0] v);
        logic [CNT_W-1:0] n;
        n = {CNT_W{1'b0}};
        for (int i = 0; i < MAX_PLANE_NUMBER; i++) begin
            n = n + {{(CNT_W-1){1'b0}}, ~v[i]};
        end
        return n;
    endfunction

    // Return a vector with only bit p set.
    function automatic logic [MAX_PLANE_NUMBER-1:0] plane_mask(input logic [PID_W-1:0] p);
        return {{(MAX_PLANE_NUMBER-1){1'b0}}, 1'b1} << p;
    endfunction

    state_t                      state_r;
    logic                        alloc_ready_r;
    logic [HID_W-1:0]            host_r;
    logic                        any_r;
    logic [PID_W-1:0]            plane_r;
    logic                        grant_valid_r;
    logic                        grant_ok_r;
    logic [HID_W-1:0]            grant_host_r;
    logic [PID_W-1:0]            grant_plane_r;
    logic [MAX_PLANE_NUMBER-1:0] bitmap_r;
    logic [HID_W-1:0]            owner_r [MAX_PLANE_NUMBER];
    logic [QCNT_W-1:0]           count_r [MAX_HOST_NUMBER];
    logic [CNT_W-1:0]            free_count_r;
    logic                        err_r;

    logic                        low_found_s;
    logic [PID_W-1:0]            low_idx_s;
    logic                        found_s;
    logic [PID_W-1:0]            cand_s;
    logic                        quota_full_s;
    logic                        commit_s;
    logic                        free_hit_s;
    logic                        err_s;
    logic [MAX_PLANE_NUMBER-1:0] bitmap_nxt_s;
    logic [QCNT_W-1:0]           count_nxt_s [MAX_HOST_NUMBER];

    // Search the registered bitmap. A plane released this cycle is not seen yet.
    // Scan from the top down so that the lowest free index is the one kept.
    always_comb begin
        low_found_s = 1'b0;
        low_idx_s   = {PID_W{1'b0}};
        for (int i = MAX_PLANE_NUMBER - 1; i >= 0; i--) begin
            low_idx_s   = bitmap_r[i] ? low_idx_s : PID_W'(i);
            low_found_s = low_found_s | ~bitmap_r[i];
        end
        if (any_r) begin
            found_s = low_found_s;
            cand_s  = low_idx_s;
        end else begin
            found_s = ~bitmap_r[plane_r];
            cand_s  = plane_r;
        end
        quota_full_s = (count_r[host_r] == QCNT_W'(HOST_QUOTA));
        commit_s     = (state_r == ST_SEARCH) && found_s && !quota_full_s;
    end

    // Apply the commit and the release to the bitmap and the per-host counts.
    // A commit and a release never touch the same plane: the commit picks a
    // plane whose bit is clear, and the release hits a plane whose bit is set.
    always_comb begin
        free_hit_s   = i_free_valid & bitmap_r[i_free_plane_id];
        err_s        = i_free_valid & ~bitmap_r[i_free_plane_id];
        bitmap_nxt_s = (bitmap_r | (commit_s ? plane_mask(cand_s) : {MAX_PLANE_NUMBER{1'b0}}))
                     & ~(free_hit_s ? plane_mask(i_free_plane_id) : {MAX_PLANE_NUMBER{1'b0}});
        for (int h = 0; h < MAX_HOST_NUMBER; h++) begin
            count_nxt_s[h] = count_r[h];
            case ({commit_s && (host_r == HID_W'(h)),
                   free_hit_s && (owner_r[i_free_plane_id] == HID_W'(h))})
                2'b10: begin
                    if (count_r[h] != QCNT_W'(HOST_QUOTA)) begin
                        count_nxt_s[h] = count_r[h] + {{(QCNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        count_nxt_s[h] = count_r[h];
                    end
                end
                2'b01: begin
                    if (count_r[h] != {QCNT_W{1'b0}}) begin
                        count_nxt_s[h] = count_r[h] - {{(QCNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        count_nxt_s[h] = count_r[h];
                    end
                end
                default: count_nxt_s[h] = count_r[h];
            endcase
        end
    end

    // Bitmap, owner table, counts, free count and the error pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bitmap_r     <= {MAX_PLANE_NUMBER{1'b0}};
            free_count_r <= CNT_W'(MAX_PLANE_NUMBER);
            err_r        <= 1'b0;
            for (int p = 0; p < MAX_PLANE_NUMBER; p++) owner_r[p] <= {HID_W{1'b0}};
            for (int h = 0; h < MAX_HOST_NUMBER; h++) count_r[h] <= {QCNT_W{1'b0}};
        end else begin
            bitmap_r     <= bitmap_nxt_s;
            free_count_r <= count_zeros(bitmap_nxt_s);
            err_r        <= err_s;
            for (int h = 0; h < MAX_HOST_NUMBER; h++) count_r[h] <= count_nxt_s[h];
            if (commit_s) begin
                owner_r[cand_s] <= host_r;
            end
        end
    end

    // Allocation FSM and the registered request and grant fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            alloc_ready_r <= 1'b1;
            host_r        <= {HID_W{1'b0}};
            any_r         <= 1'b0;
            plane_r       <= {PID_W{1'b0}};
            grant_valid_r <= 1'b0;
            grant_ok_r    <= 1'b0;
            grant_host_r  <= {HID_W{1'b0}};
            grant_plane_r <= {PID_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_alloc_valid && alloc_ready_r) begin
                        host_r        <= i_alloc_host_id;
                        any_r         <= i_alloc_any;
                        plane_r       <= i_alloc_plane_id;
                        alloc_ready_r <= 1'b0;
                        state_r       <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    grant_valid_r <= 1'b1;
                    grant_ok_r    <= commit_s;
                    grant_host_r  <= host_r;
                    grant_plane_r <= commit_s ? cand_s : {PID_W{1'b0}};
                    state_r       <= ST_GRANT;
                end
                ST_GRANT: begin
                    if (i_grant_ready) begin
                        grant_valid_r <= 1'b0;
                        alloc_ready_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end
                end
                default: begin
                    grant_valid_r <= 1'b0;
                    alloc_ready_r <= 1'b1;
                    state_r       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_alloc_ready    = alloc_ready_r;
    assign o_grant_valid    = grant_valid_r;
    assign o_grant_ok       = grant_ok_r;
    assign o_grant_host_id  = grant_host_r;
    assign o_grant_plane_id = grant_plane_r;
    assign o_busy_bitmap    = bitmap_r;
    assign o_free_count     = free_count_r;
    assign o_err_free_idle  = err_r;

endmodule

// File: tb/tb_plane_bitmap_allocator.sv
// -----------------------------------------------------------------------------
// tb_plane_bitmap_allocator
//   Directed self-checking bench for plane_bitmap_allocator at its default
//   parameters: 4 hosts, 16 planes, quota 4.
//   Inputs are driven on the falling edge, and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_plane_bitmap_allocator;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_alloc_valid = 1'b0;
    logic [1:0]  i_alloc_host_id = 2'd0;
    logic        i_alloc_any = 1'b0;
    logic [3:0]  i_alloc_plane_id = 4'd0;
    logic        o_alloc_ready;
    logic        o_grant_valid;
    logic        o_grant_ok;
    logic [1:0]  o_grant_host_id;
    logic [3:0]  o_grant_plane_id;
    logic        i_grant_ready = 1'b0;
    logic        i_free_valid = 1'b0;
    logic [3:0]  i_free_plane_id = 4'd0;
    logic [15:0] o_busy_bitmap;
    logic [4:0]  o_free_count;
    logic        o_err_free_idle;

    int vectors = 0;
    int errors  = 0;

    plane_bitmap_allocator dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_alloc_valid    (i_alloc_valid),
        .i_alloc_host_id  (i_alloc_host_id),
        .i_alloc_any      (i_alloc_any),
        .i_alloc_plane_id (i_alloc_plane_id),
        .o_alloc_ready    (o_alloc_ready),
        .o_grant_valid    (o_grant_valid),
        .o_grant_ok       (o_grant_ok),
        .o_grant_host_id  (o_grant_host_id),
        .o_grant_plane_id (o_grant_plane_id),
        .i_grant_ready    (i_grant_ready),
        .i_free_valid     (i_free_valid),
        .i_free_plane_id  (i_free_plane_id),
        .o_busy_bitmap    (o_busy_bitmap),
        .o_free_count     (o_free_count),
        .o_err_free_idle  (o_err_free_idle)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Release one plane for one cycle.
    task automatic do_free(input logic [3:0] p);
        i_free_valid    = 1'b1;
        i_free_plane_id = p;
        @(negedge i_clk);
        i_free_valid    = 1'b0;
    endtask

    // One full request/grant transaction with i_grant_ready asserted in GRANT.
    task automatic do_req(input logic [1:0] h, input logic any, input logic [3:0] p,
                          output logic ok, output logic [3:0] pid, output logic [1:0] hid);
        int waited;
        waited = 0;
        while (o_alloc_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk);
            waited++;
        end
        vectors++;
        if (o_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_timeout: o_alloc_ready=%b required 1", o_alloc_ready);
        end
        i_alloc_valid    = 1'b1;
        i_alloc_host_id  = h;
        i_alloc_any      = any;
        i_alloc_plane_id = p;
        @(negedge i_clk);
        i_alloc_valid = 1'b0;
        vectors++;
        if (o_alloc_ready !== 1'b0 || o_grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL search_state: ready=%b grant_valid=%b required 0/0", o_alloc_ready, o_grant_valid);
        end
        @(negedge i_clk);
        waited = 0;
        while (o_grant_valid !== 1'b1 && waited < 10) begin
            @(negedge i_clk);
            waited++;
        end
        vectors++;
        if (o_grant_valid !== 1'b1 || waited != 0) begin
            errors++;
            $display("FAIL grant_latency: grant_valid=%b extra_cycles=%0d required 1/0", o_grant_valid, waited);
        end
        ok  = o_grant_ok;
        pid = o_grant_plane_id;
        hid = o_grant_host_id;
        i_grant_ready = 1'b1;
        @(negedge i_clk);
        i_grant_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (o_alloc_ready !== 1'b1 || o_grant_valid !== 1'b0 || o_grant_ok !== 1'b0 ||
            o_grant_host_id !== 2'd0 || o_grant_plane_id !== 4'd0 || o_busy_bitmap !== 16'h0000 ||
            o_free_count !== 5'd16 || o_err_free_idle !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b gv=%b ok=%b hid=%0d pid=%0d bm=%h fc=%0d err=%b required 1 0 0 0 0 0000 16 0",
                     o_alloc_ready, o_grant_valid, o_grant_ok, o_grant_host_id, o_grant_plane_id,
                     o_busy_bitmap, o_free_count, o_err_free_idle);
        end
    endtask

    task automatic test_any_alloc();
        logic ok; logic [3:0] pid; logic [1:0] hid;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_req(2'(i % 4), 1'b1, 4'd0, ok, pid, hid);
            vectors++;
            if (ok !== 1'b1 || pid !== 4'(i) || hid !== 2'(i % 4)) begin
                errors++;
                $display("FAIL any_alloc_%0d: ok=%b pid=%0d hid=%0d required 1 %0d %0d", i, ok, pid, hid, i, i % 4);
            end
        end
        do_req(2'd0, 1'b1, 4'd0, ok, pid, hid);
        vectors++;
        if (ok !== 1'b0 || pid !== 4'd0 || o_free_count !== 5'd0 || o_busy_bitmap !== 16'hFFFF) begin
            errors++;
            $display("FAIL any_alloc_full: ok=%b pid=%0d fc=%0d bm=%h required 0 0 0 ffff", ok, pid, o_free_count, o_busy_bitmap);
        end
    endtask

    task automatic test_quota();
        logic ok; logic [3:0] pid; logic [1:0] hid;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_req(2'd2, 1'b1, 4'd0, ok, pid, hid);
            vectors++;
            if (i < 4 && (ok !== 1'b1 || pid !== 4'(i) || hid !== 2'd2)) begin
                errors++;
                $display("FAIL quota_grant_%0d: ok=%b pid=%0d hid=%0d required 1 %0d 2", i, ok, pid, hid, i);
            end else if (i == 4 && (ok !== 1'b0 || pid !== 4'd0 || hid !== 2'd2)) begin
                errors++;
                $display("FAIL quota_deny: ok=%b pid=%0d hid=%0d required 0 0 2", ok, pid, hid);
            end
        end
        vectors++;
        if (o_busy_bitmap !== 16'h000F || o_free_count !== 5'd12) begin
            errors++;
            $display("FAIL quota_bitmap: bm=%h fc=%0d required 000f 12", o_busy_bitmap, o_free_count);
        end
        // Releasing one of host 2's planes frees one unit of its quota.
        do_free(4'd1);
        do_req(2'd2, 1'b1, 4'd0, ok, pid, hid);
        vectors++;
        if (ok !== 1'b1 || pid !== 4'd1 || o_busy_bitmap !== 16'h000F) begin
            errors++;
            $display("FAIL quota_after_free: ok=%b pid=%0d bm=%h required 1 1 000f", ok, pid, o_busy_bitmap);
        end
    endtask

    task automatic test_specific();
        logic ok; logic [3:0] pid; logic [1:0] hid;
        do_reset();
        do_req(2'd1, 1'b0, 4'd7, ok, pid, hid);
        vectors++;
        if (ok !== 1'b1 || pid !== 4'd7 || o_busy_bitmap !== 16'h0080) begin
            errors++;
            $display("FAIL specific_first: ok=%b pid=%0d bm=%h required 1 7 0080", ok, pid, o_busy_bitmap);
        end
        do_req(2'd3, 1'b0, 4'd7, ok, pid, hid);
        vectors++;
        if (ok !== 1'b0 || pid !== 4'd0 || hid !== 2'd3 || o_busy_bitmap !== 16'h0080) begin
            errors++;
            $display("FAIL specific_busy: ok=%b pid=%0d hid=%0d bm=%h required 0 0 3 0080", ok, pid, hid, o_busy_bitmap);
        end
        do_free(4'd7);
        vectors++;
        if (o_busy_bitmap !== 16'h0000 || o_free_count !== 5'd16 || o_err_free_idle !== 1'b0) begin
            errors++;
            $display("FAIL specific_release: bm=%h fc=%0d err=%b required 0000 16 0", o_busy_bitmap, o_free_count, o_err_free_idle);
        end
        do_req(2'd3, 1'b0, 4'd7, ok, pid, hid);
        vectors++;
        if (ok !== 1'b1 || pid !== 4'd7 || hid !== 2'd3) begin
            errors++;
            $display("FAIL specific_retry: ok=%b pid=%0d hid=%0d required 1 7 3", ok, pid, hid);
        end
    endtask

    task automatic test_same_cycle_release();
        logic ok; logic [3:0] pid; logic [1:0] hid;
        do_reset();
        for (int i = 0; i < 16; i++) do_req(2'(i % 4), 1'b1, 4'd0, ok, pid, hid);
        // Host 0 starts a search. Plane 0 is released during SEARCH, so it is not yet a candidate.
        i_alloc_valid   = 1'b1;
        i_alloc_host_id = 2'd0;
        i_alloc_any     = 1'b1;
        @(negedge i_clk);
        i_alloc_valid   = 1'b0;
        do_free(4'd0);
        vectors++;
        if (o_grant_valid !== 1'b1 || o_grant_ok !== 1'b0 || o_busy_bitmap !== 16'hFFFE || o_free_count !== 5'd1) begin
            errors++;
            $display("FAIL same_cycle_deny: gv=%b ok=%b bm=%h fc=%0d required 1 0 fffe 1",
                     o_grant_valid, o_grant_ok, o_busy_bitmap, o_free_count);
        end
        i_grant_ready = 1'b1;
        @(negedge i_clk);
        i_grant_ready = 1'b0;
        do_req(2'd0, 1'b1, 4'd0, ok, pid, hid);
        vectors++;
        if (ok !== 1'b1 || pid !== 4'd0 || o_busy_bitmap !== 16'hFFFF) begin
            errors++;
            $display("FAIL same_cycle_retry: ok=%b pid=%0d bm=%h required 1 0 ffff", ok, pid, o_busy_bitmap);
        end
    endtask

    task automatic test_err_backpressure();
        logic ok; logic [3:0] pid; logic [1:0] hid;
        do_reset();
        do_req(2'd1, 1'b1, 4'd0, ok, pid, hid);
        do_free(4'd5);
        vectors++;
        if (o_err_free_idle !== 1'b1 || o_busy_bitmap !== 16'h0001 || o_free_count !== 5'd15) begin
            errors++;
            $display("FAIL err_pulse: err=%b bm=%h fc=%0d required 1 0001 15", o_err_free_idle, o_busy_bitmap, o_free_count);
        end
        @(negedge i_clk);
        vectors++;
        if (o_err_free_idle !== 1'b0) begin
            errors++;
            $display("FAIL err_one_cycle: err=%b required 0", o_err_free_idle);
        end
        i_alloc_valid   = 1'b1;
        i_alloc_host_id = 2'd1;
        i_alloc_any     = 1'b1;
        @(negedge i_clk);
        i_alloc_valid   = 1'b0;
        @(negedge i_clk);
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (o_grant_valid !== 1'b1 || o_grant_ok !== 1'b1 || o_grant_plane_id !== 4'd1 ||
                o_grant_host_id !== 2'd1 || o_alloc_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_%0d: gv=%b ok=%b pid=%0d hid=%0d rdy=%b required 1 1 1 1 0",
                         c, o_grant_valid, o_grant_ok, o_grant_plane_id, o_grant_host_id, o_alloc_ready);
            end
            @(negedge i_clk);
        end
        i_grant_ready = 1'b1;
        @(negedge i_clk);
        i_grant_ready = 1'b0;
        vectors++;
        if (o_grant_valid !== 1'b0 || o_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: gv=%b rdy=%b required 0 1", o_grant_valid, o_alloc_ready);
        end
    endtask

    task automatic test_back_to_back();
        int grants;
        do_reset();
        grants = 0;
        i_alloc_valid   = 1'b1;
        i_alloc_host_id = 2'd0;
        i_alloc_any     = 1'b1;
        i_grant_ready   = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge i_clk);
            vectors++;
            if (o_grant_valid !== (k % 3 == 2)) begin
                errors++;
                $display("FAIL b2b_valid_%0d: gv=%b required %0d", k, o_grant_valid, (k % 3 == 2));
            end
            if (o_grant_valid === 1'b1) begin
                vectors++;
                if (o_grant_ok !== 1'b1 || o_grant_plane_id !== 4'(grants)) begin
                    errors++;
                    $display("FAIL b2b_grant_%0d: ok=%b pid=%0d required 1 %0d", grants, o_grant_ok, o_grant_plane_id, grants);
                end
                grants++;
            end
        end
        i_alloc_valid = 1'b0;
        i_grant_ready = 1'b0;
        vectors++;
        if (o_busy_bitmap !== 16'h0007 || o_free_count !== 5'd13) begin
            errors++;
            $display("FAIL b2b_bitmap: bm=%h fc=%0d required 0007 13", o_busy_bitmap, o_free_count);
        end
    endtask

    task automatic test_reset_grant();
        do_reset();
        i_alloc_valid   = 1'b1;
        i_alloc_host_id = 2'd3;
        i_alloc_any     = 1'b1;
        @(negedge i_clk);
        i_alloc_valid   = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (o_grant_valid !== 1'b1 || o_busy_bitmap !== 16'h0001) begin
            errors++;
            $display("FAIL rst_grant_pre: gv=%b bm=%h required 1 0001", o_grant_valid, o_busy_bitmap);
        end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if (o_grant_valid !== 1'b0 || o_grant_ok !== 1'b0 || o_busy_bitmap !== 16'h0000 ||
            o_free_count !== 5'd16 || o_alloc_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_grant_async: gv=%b ok=%b bm=%h fc=%0d rdy=%b required 0 0 0000 16 1",
                     o_grant_valid, o_grant_ok, o_busy_bitmap, o_free_count, o_alloc_ready);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        vectors++;
        if (o_alloc_ready !== 1'b1 || o_grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_grant_after: rdy=%b gv=%b required 1 0", o_alloc_ready, o_grant_valid);
        end
    endtask

    initial begin
        test_reset();
        test_any_alloc();
        test_quota();
        test_specific();
        test_same_cycle_release();
        test_err_backpressure();
        test_back_to_back();
        test_reset_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
